// File: rtl/tdc_stop_if.sv
// Control/status bundle between the timing counters, the TDC and the uC.
//   slave  modport (sequencer): meas_en, tos_mark, slow_tick_next, pps_raw_logic in;
//                               tdc_stop_next, stop_tos_count, tick_count, meas_valid,
//                               err_missed, err_overrun out.
//   master modport (driver/bench): the mirror image.
interface tdc_stop_if #(
  parameter int unsigned TickW = 16
);
  logic             meas_en;
  logic             tos_mark;
  logic             slow_tick_next;
  logic             pps_raw_logic;
  logic             tdc_stop_next;
  logic             stop_tos_count;
  logic [TickW-1:0] tick_count;
  logic             meas_valid;
  logic             err_missed;
  logic             err_overrun;

  modport slave (
    input  meas_en, tos_mark, slow_tick_next, pps_raw_logic,
    output tdc_stop_next, stop_tos_count, tick_count, meas_valid, err_missed, err_overrun
  );

  modport master (
    output meas_en, tos_mark, slow_tick_next, pps_raw_logic,
    input  tdc_stop_next, stop_tos_count, tick_count, meas_valid, err_missed, err_overrun
  );
endinterface

// File: rtl/tdc_stop_sequencer.sv
// Sequences the TDC stop once per second: from top-of-second it counts slow
// ticks, waits for the synchronised PPS edge, then stops on the first slow tick
// at least GuardCycles after that edge and reports the inclusive tick index.
//   clk_tf : 19.2 MHz clock (only clock)
//   rst    : synchronous, active-high reset
//   tdc    : tdc_stop_if.slave -- strobes/level in, stop/status out
//            (tdc_stop_next, meas_valid, err_* are zero-latency decodes of
//             registered state and the input strobes; the rest are flops)
module tdc_stop_sequencer #(
  parameter int unsigned GuardCycles = 3,
  parameter int unsigned TickW       = 16
) (
  input  logic       clk_tf,
  input  logic       rst,
  tdc_stop_if.slave  tdc
);

  localparam int unsigned GuardW = (GuardCycles < 2) ? 1 : $clog2(GuardCycles + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [1:0] ARMED = 2'd3;

  localparam logic [TickW-1:0] TickMax = {TickW{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [TickW-1:0]  cnt_q, cnt_d;
  logic [TickW-1:0]  tick_count_q, tick_count_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              stc_q, stc_d;
  logic              s1_q, s2_q, s3_q;

  logic              rise_det;
  logic [TickW-1:0]  cnt_inc;
  logic              stop_c, missed_c, overrun_c;

  assign rise_det = s2_q & ~s3_q;
  // Saturating increment: the index never wraps back to a small value.
  assign cnt_inc  = (cnt_q == TickMax) ? cnt_q : cnt_q + TickW'(1);

  // Next-state and strobe decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tick_count_d = tick_count_q;
    guard_d      = guard_q;
    stop_c       = 1'b0;
    missed_c     = 1'b0;
    overrun_c    = 1'b0;

    if (state_q == IDLE) begin
      if (tdc.meas_en && tdc.tos_mark) begin
        state_d = COUNT;
        cnt_d   = '0;
      end
    end else if (!tdc.meas_en) begin
      // Abort silently; tick_count keeps the last result.
      state_d = IDLE;
    end else if (tdc.tos_mark) begin
      // New second starts this edge; a coincident tick belongs to nobody.
      cnt_d = '0;
      if (state_q == COUNT) begin
        missed_c = 1'b1;
        if (rise_det) begin
          state_d = GUARD;
          guard_d = GuardW'(1);
        end
      end else begin
        overrun_c = 1'b1;
        state_d   = COUNT;
      end
    end else begin
      if (tdc.slow_tick_next) begin
        cnt_d = cnt_inc;
      end
      unique case (state_q)
        COUNT: begin
          if (rise_det) begin
            state_d = GUARD;
            guard_d = GuardW'(1);
          end
        end
        GUARD: begin
          // guard_q counts cycles since D; a tick on the expiry cycle is eligible.
          if (guard_q == GuardW'(GuardCycles)) begin
            if (tdc.slow_tick_next) begin
              stop_c = 1'b1;
            end else begin
              state_d = ARMED;
            end
          end else begin
            guard_d = guard_q + GuardW'(1);
          end
        end
        ARMED: begin
          if (tdc.slow_tick_next) begin
            stop_c = 1'b1;
          end
        end
        default: ;
      endcase
      if (stop_c) begin
        tick_count_d = cnt_inc;
        state_d      = IDLE;
      end
    end

    stc_d = (state_d != IDLE);
  end

  // State, counters and PPS synchroniser.
  always_ff @(posedge clk_tf) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tick_count_q <= '0;
      guard_q      <= '0;
      stc_q        <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_count_q <= tick_count_d;
      guard_q      <= guard_d;
      stc_q        <= stc_d;
      s1_q         <= tdc.pps_raw_logic;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
    end
  end

  assign tdc.tdc_stop_next  = stop_c;
  assign tdc.meas_valid     = stop_c;
  assign tdc.err_missed     = missed_c;
  assign tdc.err_overrun    = overrun_c;
  assign tdc.stop_tos_count = stc_q;
  assign tdc.tick_count     = tick_count_q;

endmodule

// File: tb/tb_tdc_stop_sequencer.sv
// Directed bench for tdc_stop_sequencer: each scenario replays one or more
// seconds cycle by cycle (tos_mark at chosen cycles, slow ticks every 1920
// cycles, PPS raised two cycles before the wanted rise_det cycle D) and the
// recorded events are compared against hand-computed cycle numbers.
module tb_tdc_stop_sequencer;

  localparam int unsigned TickW   = 16;
  localparam int          TickPer = 1920;

  logic clk_tf = 1'b0;
  logic rst    = 1'b1;

  tdc_stop_if #(.TickW(TickW)) bus ();

  tdc_stop_sequencer #(.GuardCycles(3), .TickW(TickW)) dut (
    .clk_tf (clk_tf),
    .rst    (rst),
    .tdc    (bus)
  );

  always #5 clk_tf = ~clk_tf;

  int n_checks = 0;
  int n_errors = 0;

  int o_stop_cyc, o_stops, o_tc, o_em, o_eo, o_viol;
  int o_stc_first, o_stc_last, o_stc_cnt, o_tc0, o_tc_end, o_rst_stc, o_rst_tc;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.meas_en        = 1'b0;
    bus.tos_mark       = 1'b0;
    bus.slow_tick_next = 1'b0;
    bus.pps_raw_logic  = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (4) @(posedge clk_tf);
    #1 rst = 1'b0;
  endtask

  // Cycle 0 is the first cycle after entry (entry is posedge+1).
  task automatic run_scen(input int ncyc, input int tos_a, input int tos_b, input int d,
                          input int en_off, input int rst_at, input int rst_len);
    o_stop_cyc = -1; o_stops = 0; o_tc = -1; o_em = -1; o_eo = -1; o_viol = 0;
    o_stc_first = -1; o_stc_last = -1; o_stc_cnt = 0; o_tc0 = -1; o_tc_end = -1;
    o_rst_stc = -1; o_rst_tc = -1;
    for (int c = 0; c < ncyc; c++) begin
      bus.tos_mark       = (c == tos_a) || (c == tos_b);
      bus.slow_tick_next = (c > 0) && (c % TickPer == 0);
      bus.pps_raw_logic  = (d >= 2) && (c >= d - 2);
      bus.meas_en        = !((en_off >= 0) && (c >= en_off));
      rst                = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + rst_len);
      @(negedge clk_tf);
      if (c == 0) o_tc0 = int'(bus.tick_count);
      if (c == ncyc - 1) o_tc_end = int'(bus.tick_count);
      if (bus.tdc_stop_next === 1'b1) begin
        o_stops++;
        if (o_stop_cyc < 0) o_stop_cyc = c;
      end
      if ((o_stop_cyc >= 0) && (c == o_stop_cyc + 1)) o_tc = int'(bus.tick_count);
      if ((bus.err_missed === 1'b1) && (o_em < 0)) o_em = c;
      if ((bus.err_overrun === 1'b1) && (o_eo < 0)) o_eo = c;
      if ((bus.meas_valid !== bus.tdc_stop_next) ||
          (int'(bus.err_missed) + int'(bus.err_overrun) + int'(bus.tdc_stop_next) > 1))
        o_viol++;
      if (bus.stop_tos_count === 1'b1) begin
        o_stc_cnt++;
        if (o_stc_first < 0) o_stc_first = c;
        o_stc_last = c;
      end
      if ((rst_at >= 0) && (c == rst_at + rst_len)) begin
        o_rst_stc = int'(bus.stop_tos_count);
        o_rst_tc  = int'(bus.tick_count);
      end
      @(posedge clk_tf);
      #1;
    end
    drive_idle();
    rst = 1'b0;
    repeat (5) @(posedge clk_tf);
    #1;
  endtask

  task automatic expect_scen(input string nm, input int stop_cyc, input int stops, input int tc,
                             input int em, input int eo, input int stc_first, input int stc_last,
                             input int stc_cnt);
    check_val({nm, ".stop_cyc"},  o_stop_cyc,  stop_cyc);
    check_val({nm, ".stops"},     o_stops,     stops);
    check_val({nm, ".tick_count"}, o_tc,       tc);
    check_val({nm, ".err_missed"}, o_em,       em);
    check_val({nm, ".err_overrun"}, o_eo,      eo);
    check_val({nm, ".stc_first"}, o_stc_first, stc_first);
    check_val({nm, ".stc_last"},  o_stc_last,  stc_last);
    check_val({nm, ".stc_cnt"},   o_stc_cnt,   stc_cnt);
    check_val({nm, ".strobe_rule"}, o_viol,    0);
  endtask

  initial begin
    drive_idle();
    do_reset();
    @(negedge clk_tf);
    check_val("rst.stop_tos_count", int'(bus.stop_tos_count), 0);
    check_val("rst.tick_count",     int'(bus.tick_count),     0);
    check_val("rst.tdc_stop_next",  int'(bus.tdc_stop_next),  0);
    check_val("rst.meas_valid",     int'(bus.meas_valid),     0);
    check_val("rst.err_missed",     int'(bus.err_missed),     0);
    check_val("rst.err_overrun",    int'(bus.err_overrun),    0);
    @(posedge clk_tf);
    #1;

    // Nominal: D=5000, stop on tick 5760 = third tick.
    run_scen(5800, 0, -1, 5000, -1, -1, 0);
    expect_scen("nominal", 5760, 1, 3, -1, -1, 1, 5760, 5760);

    // rst held 4 cycles while ARMED; previous result (3) still held at entry.
    run_scen(5800, 0, -1, 5000, -1, 5100, 4);
    check_val("rst_armed.tc_held", o_tc0, 3);
    check_val("rst_armed.stc_after", o_rst_stc, 0);
    check_val("rst_armed.tc_after", o_rst_tc, 0);
    expect_scen("rst_armed", -1, 0, -1, -1, -1, 1, 5100, 5100);

    // Guard boundary: D=5757 makes tick 5760 eligible exactly on expiry.
    do_reset();
    run_scen(5800, 0, -1, 5757, -1, -1, 0);
    expect_scen("guard_5757", 5760, 1, 3, -1, -1, 1, 5760, 5760);

    // D=5758: tick 5760 too early, stop slips to 7680.
    do_reset();
    run_scen(7700, 0, -1, 5758, -1, -1, 0);
    expect_scen("guard_5758", 7680, 1, 4, -1, -1, 1, 7680, 7680);

    // meas_en dropped in GUARD: IDLE next cycle, no strobes, result 4 held.
    run_scen(6000, 0, -1, 5000, 5002, -1, 0);
    expect_scen("en_drop", -1, 0, -1, -1, -1, 1, 5002, 5002);
    check_val("en_drop.tc_hold", o_tc_end, 4);

    // Missed PPS: err_missed at 19199, counter restarts; edge 20000 -> stop 21120, count 2.
    do_reset();
    run_scen(21200, 0, 19199, 20000, -1, -1, 0);
    expect_scen("missed", 21120, 1, 2, 19199, -1, 1, 21120, 21120);

    // Overrun: D=19198, tos at 19199 in GUARD -> err_overrun, back to COUNT.
    do_reset();
    run_scen(19300, 0, 19199, 19198, -1, -1, 0);
    expect_scen("overrun", -1, 0, -1, -1, 19199, 1, 19299, 19299);

    // meas_en low throughout three short seconds: nothing happens.
    do_reset();
    run_scen(3000, 0, 1000, 500, 0, -1, 0);
    expect_scen("disabled", -1, 0, -1, -1, -1, -1, -1, 0);

    // tos_mark and tick together at 1920 inside COUNT: tick dropped, count 2 at 5760.
    do_reset();
    run_scen(5800, 0, 1920, 5000, -1, -1, 0);
    expect_scen("tos_tick", 5760, 1, 2, 1920, -1, 1, 5760, 5760);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
